// File: rtl/bat_amateur_pkg.sv
// Shared constants and state encoding for the BatAmateur program loader.
package bat_amateur_pkg;

  localparam int unsigned HDR_BYTES      = 4;
  localparam int unsigned BYTES_PER_WORD = 2;
  localparam int unsigned ST_W           = 4;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t S_ADDR_HI = 4'd0;
  localparam state_t S_ADDR_LO = 4'd1;
  localparam state_t S_CNT_HI  = 4'd2;
  localparam state_t S_CNT_LO  = 4'd3;
  localparam state_t S_DATA_HI = 4'd4;
  localparam state_t S_DATA_LO = 4'd5;
  localparam state_t S_WRITE   = 4'd6;
  localparam state_t S_CHECK   = 4'd7;
  localparam state_t S_RUN     = 4'd8;
  localparam state_t S_ERR     = 4'd9;

  localparam logic [15:0] RST_ADDR = 16'h0000;

endpackage

// File: rtl/bat_amateur_loader_cksum.sv
// Running XOR checksum over accepted frame bytes, compared against the CHK byte.
module bat_amateur_loader_cksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_acc,
  input  logic [7:0] i_byte,
  output logic       o_match_c
);

  logic [7:0] r_sum;

  // Clear has priority so a reload never inherits a stale sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_sum <= 8'h00;
    else if (i_clr) r_sum <= 8'h00;
    else if (i_acc) r_sum <= r_sum ^ i_byte;
  end

  // Incoming byte versus the sum of everything before it.
  assign o_match_c = (i_byte == r_sum);

endmodule

// File: rtl/bat_amateur_loader.sv
// Frame-driven boot loader: writes payload words to memory while holding the CPU halted.
module bat_amateur_loader
  import bat_amateur_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  output logic                  RX_READY,
  input  logic                  LOAD_REQ,
  output logic                  HALT,
  output logic                  WRITE_EN,
  output logic [ADDR_WIDTH-1:0] ADDRESS_BUS,
  output logic [DATA_WIDTH-1:0] DATA_BUS,
  output logic                  ERROR
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_error;

  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [15:0]           w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  w_error_nxt;
  logic                  w_rx_ready;
  logic                  w_accept;
  logic                  w_ck_clr;
  logic                  w_ck_acc;
  logic                  w_ck_match;

  // Ready depends on state only; upstream holds bytes while we write or run.
  always_comb begin
    w_rx_ready = 1'b0;
    case (r_state)
      S_ADDR_HI, S_ADDR_LO, S_CNT_HI, S_CNT_LO,
      S_DATA_HI, S_DATA_LO, S_CHECK: w_rx_ready = 1'b1;
      default:                       w_rx_ready = 1'b0;
    endcase
  end

  assign w_accept = RX_VALID & w_rx_ready;

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_ADDR_HI;
      r_addr  <= ADDR_WIDTH'(RST_ADDR);
      r_cnt   <= 16'h0000;
      r_data  <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_error <= w_error_nxt;
    end
  end

  // Frame parsing, write sequencing and run/error handling.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_error_nxt = r_error;
    w_ck_clr    = 1'b0;
    w_ck_acc    = w_accept && (r_state != S_CHECK);
    case (r_state)
      S_ADDR_HI: if (w_accept) begin
        w_addr_nxt  = {RX_DATA, r_addr[7:0]};
        w_state_nxt = S_ADDR_LO;
      end
      S_ADDR_LO: if (w_accept) begin
        w_addr_nxt  = {r_addr[ADDR_WIDTH-1:8], RX_DATA};
        w_state_nxt = S_CNT_HI;
      end
      S_CNT_HI: if (w_accept) begin
        w_cnt_nxt   = {RX_DATA, r_cnt[7:0]};
        w_state_nxt = S_CNT_LO;
      end
      S_CNT_LO: if (w_accept) begin
        w_cnt_nxt   = {r_cnt[15:8], RX_DATA};
        w_state_nxt = ({r_cnt[15:8], RX_DATA} == 16'h0000) ? S_CHECK : S_DATA_HI;
      end
      S_DATA_HI: if (w_accept) begin
        w_data_nxt  = {RX_DATA, r_data[7:0]};
        w_state_nxt = S_DATA_LO;
      end
      S_DATA_LO: if (w_accept) begin
        w_data_nxt  = {r_data[DATA_WIDTH-1:8], RX_DATA};
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
        w_cnt_nxt   = r_cnt - 16'd1;
        w_state_nxt = (r_cnt == 16'd1) ? S_CHECK : S_DATA_HI;
      end
      S_CHECK: if (w_accept) begin
        if (w_ck_match) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_ERR;
          w_error_nxt = 1'b1;
        end
      end
      S_RUN, S_ERR: if (LOAD_REQ) begin
        w_ck_clr    = 1'b1;
        w_error_nxt = 1'b0;
        w_state_nxt = S_ADDR_HI;
      end
      default: w_state_nxt = S_ADDR_HI;
    endcase
  end

  bat_amateur_loader_cksum u_cksum (
    .clk       (CLK),
    .rst_n     (RESET),
    .i_clr     (w_ck_clr),
    .i_acc     (w_ck_acc),
    .i_byte    (RX_DATA),
    .o_match_c (w_ck_match)
  );

  // Outputs decode from registered state; buses release once the CPU runs.
  assign RX_READY    = w_rx_ready;
  assign HALT        = (r_state != S_RUN);
  assign WRITE_EN    = (r_state == S_WRITE);
  assign ERROR       = r_error;
  assign ADDRESS_BUS = HALT ? r_addr : {ADDR_WIDTH{1'bz}};
  assign DATA_BUS    = HALT ? r_data : {DATA_WIDTH{1'bz}};

endmodule
